// File: rtl/npc_ifu_pkg.sv
// Shared definitions for the NPC instruction fetch unit.
package npc_ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int          DEF_AW       = 64;
    localparam int          DEF_IW       = 32;
    localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;

    // Instructions are 32-bit aligned: any low-bit set means misaligned.
    localparam logic [1:0]  MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: holds pc, issues one imem read per fetch_en, returns instr_en/fetch_err pulses.
// Latency: fetch_en at N -> req_valid N+1 -> (ready N+1, rsp N+2) -> instr_en N+3.
// Backpressure: request held stable until imem_req_ready; responses are never stalled.
module ifu_fetch
    import npc_ifu_pkg::*;
#(
    parameter int            AW       = DEF_AW,
    parameter int            IW       = DEF_IW,
    parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC),
    parameter int            TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic          pc_ld,
    input  logic [AW-1:0] next_pc,
    input  logic          flush,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [IW-1:0] imem_rsp_data,
    input  logic          imem_rsp_err,
    output logic [IW-1:0] instr_out,
    output logic          instr_en,
    output logic [AW-1:0] pc_out,
    output logic [AW-1:0] fetch_addr,
    output logic          fetch_busy,
    output logic          fetch_err
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    fetch_state_t  state;
    logic [AW-1:0] pc;
    logic [15:0]   to_cnt;

    assign imem_req_valid = (state == REQ);
    assign fetch_busy     = (state != IDLE);
    assign pc_out         = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            imem_req_addr <= '0;
            instr_out     <= '0;
            fetch_addr    <= '0;
            instr_en      <= 1'b0;
            fetch_err     <= 1'b0;
            to_cnt        <= '0;
        end else begin
            instr_en  <= 1'b0;
            fetch_err <= 1'b0;

            if (pc_ld) begin
                pc <= next_pc;
            end

            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        if ((pc[1:0] & MISALIGN_MASK) != 2'b00) begin
                            fetch_err <= 1'b1;
                        end else begin
                            imem_req_addr <= pc;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An accepted request will produce a response, so a
                    // coincident flush must still absorb it in DRAIN.
                    if (imem_req_ready) begin
                        state  <= flush ? DRAIN : WAIT;
                        to_cnt <= '0;
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= IDLE;
                        if (!flush) begin
                            if (imem_rsp_err) begin
                                fetch_err <= 1'b1;
                            end else begin
                                instr_out  <= imem_rsp_data;
                                fetch_addr <= imem_req_addr;
                                instr_en   <= 1'b1;
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state     <= IDLE;
                        fetch_err <= !flush;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                        if (flush) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid || to_cnt == TO_LAST) begin
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a short response timeout.
module tb_ifu_fetch;
    import npc_ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        pc_ld;
    logic [63:0] next_pc;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] instr_out;
    logic        instr_en;
    logic [63:0] pc_out;
    logic [63:0] fetch_addr;
    logic        fetch_busy;
    logic        fetch_err;

    int vectors    = 0;
    int miscompares = 0;

    ifu_fetch #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .pc_ld          (pc_ld),
        .next_pc        (next_pc),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instr_out      (instr_out),
        .instr_en       (instr_en),
        .pc_out         (pc_out),
        .fetch_addr     (fetch_addr),
        .fetch_busy     (fetch_busy),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; pc_ld = 1'b0; next_pc = '0; flush = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_pc", pc_out, 64'h8000_0000);
        chk("rst_instr", 64'(instr_out), 64'h0);
        chk("rst_faddr", fetch_addr, 64'h0);
        chk("rst_raddr", imem_req_addr, 64'h0);
        chk("rst_flags", {60'h0, instr_en, fetch_err, fetch_busy, imem_req_valid}, 64'h0);

        // Best-case fetch at reset pc
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0; imem_req_ready = 1'b1;
        chk("t1_req_valid", 64'(imem_req_valid), 64'h1);
        chk("t1_req_addr", imem_req_addr, 64'h8000_0000);
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
        chk("t1_wait_noreq", 64'(imem_req_valid), 64'h0);
        step();
        imem_rsp_valid = 1'b0;
        chk("t1_instr_en", 64'(instr_en), 64'h1);
        chk("t1_instr", 64'(instr_out), 64'h0010_0073);
        chk("t1_faddr", fetch_addr, 64'h8000_0000);
        chk("t1_noerr", 64'(fetch_err), 64'h0);
        step();
        chk("t1_pulse_end", {62'h0, instr_en, fetch_busy}, 64'h0);

        // Misaligned pc
        pc_ld = 1'b1; next_pc = 64'h8000_0002;
        step();
        pc_ld = 1'b0;
        chk("t2_pc", pc_out, 64'h8000_0002);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        chk("t2_err", {61'h0, fetch_err, imem_req_valid, fetch_busy}, 64'h4);
        step();
        chk("t2_err_end", {61'h0, fetch_err, imem_req_valid, fetch_busy}, 64'h0);

        // Ready stalled 5 cycles, then bus error
        pc_ld = 1'b1; next_pc = 64'h8000_0004;
        step();
        pc_ld = 1'b0; fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 64'(imem_req_valid), 64'h1);
            chk("t3_hold_addr", imem_req_addr, 64'h8000_0004);
            if (i == 4) imem_req_ready = 1'b1;
            step();
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'hdead_beef;
        step();
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
        chk("t3_err", {62'h0, fetch_err, instr_en}, 64'h2);
        chk("t3_instr_kept", 64'(instr_out), 64'h0010_0073);

        // Timeout: accept, then no response
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0; imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step(); step(); step();
        chk("t4_before_to", {62'h0, fetch_err, fetch_busy}, 64'h1);
        step();
        chk("t4_timeout", {62'h0, fetch_err, fetch_busy}, 64'h2);
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_2222;
        step();
        imem_rsp_valid = 1'b0;
        chk("t4_late_rsp", {61'h0, instr_en, fetch_err, fetch_busy}, 64'h0);
        chk("t4_instr_kept", 64'(instr_out), 64'h0010_0073);

        // Flush in WAIT, response later, then a clean fetch
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0; imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_drain", 64'(dut.state), 64'(DRAIN));
        step(); step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        step();
        imem_rsp_valid = 1'b0;
        chk("t5_discard", {61'h0, instr_en, fetch_err, fetch_busy}, 64'h0);
        chk("t5_instr_kept", 64'(instr_out), 64'h0010_0073);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0; imem_req_ready = 1'b1;
        chk("t5_refetch_req", 64'(imem_req_valid), 64'h1);
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        chk("t5_refetch_en", 64'(instr_en), 64'h1);
        chk("t5_refetch_instr", 64'(instr_out), 64'h0000_0013);

        // pc load while a fetch is in flight
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0; imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; pc_ld = 1'b1; next_pc = 64'h8000_0100;
        step();
        pc_ld = 1'b0;
        chk("t6_pc_out", pc_out, 64'h8000_0100);
        chk("t6_req_addr_kept", imem_req_addr, 64'h8000_0004);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00a0_0093;
        step();
        imem_rsp_valid = 1'b0;
        chk("t6_instr_en", 64'(instr_en), 64'h1);
        chk("t6_faddr_old", fetch_addr, 64'h8000_0004);
        chk("t6_instr", 64'(instr_out), 64'h00a0_0093);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0; imem_req_ready = 1'b1;
        chk("t6_next_addr", imem_req_addr, 64'h8000_0100);
        step();
        imem_req_ready = 1'b0;

        // fetch_en ignored while busy, then reset mid-fetch
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        chk("t7_no_requeue", {62'h0, imem_req_valid, fetch_busy}, 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_rst_idle", 64'(fetch_busy), 64'h0);
        chk("t7_rst_pc", pc_out, 64'h8000_0000);
        chk("t7_rst_instr", 64'(instr_out), 64'h0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hffff_ffff;
        step();
        imem_rsp_valid = 1'b0;
        chk("t7_rsp_ignored", {62'h0, instr_en, fetch_err}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the decode/control stage in the single-issue NPC core.
- Holds the architectural PC and, on each fetch_en pulse from the controller, issues one instruction-memory read over a valid/ready request channel.
- Captures the response and hands it to the controller as instr_out with a one-cycle instr_en pulse.
- Detects misaligned PCs, memory errors and response timeouts, and supports flushing an in-flight fetch.

Parameters:
- AW, 64, PC and memory address width.
- IW, 32, instruction width.
- RESET_PC, 64'h8000_0000, PC value after reset.
- TIMEOUT, 255, maximum cycles spent waiting for a response before the fetch is abandoned; legal range 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset: synchronous, active-high.
- fetch_en  in  1  one-cycle request from the controller to fetch the instruction at pc.
- pc_ld  in  1  load pc with next_pc this cycle.
- next_pc  in  AW  next PC from the branch/jump/increment logic.
- flush  in  1  abandon any in-flight fetch.
- imem_req_valid  out  1  memory request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  AW  request address, latched copy of pc.
- imem_rsp_valid  in  1  response valid; no backpressure, always accepted.
- imem_rsp_data  in  IW  response instruction.
- imem_rsp_err  in  1  response carries a bus error.
- instr_out  out  IW  last fetched instruction, registered.
- instr_en  out  1  one-cycle pulse: instr_out is new and valid.
- pc_out  out  AW  current pc register.
- fetch_addr  out  AW  address of the instruction in instr_out.
- fetch_busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  one-cycle pulse on misalignment, bus error or timeout.

Behaviour:
- Reset values:
  - pc = RESET_PC; instr_out = 0; fetch_addr = 0; imem_req_addr = 0.
  - instr_en = 0; fetch_err = 0; state = IDLE; timeout counter = 0.
- pc register: pc_ld loads next_pc in any state. This never alters imem_req_addr of a fetch already started.
- FSM states are IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - On fetch_en with pc[1:0]==0: latch imem_req_addr=pc and go to REQ.
  - On fetch_en with pc[1:0]!=0: pulse fetch_err next cycle and stay in IDLE; no request is issued.
  - imem_rsp_valid in IDLE is ignored.
- REQ:
  - imem_req_valid=1 (decoded from state). imem_req_addr is held stable until accepted.
  - valid&&ready moves to WAIT and clears the counter.
  - flush before acceptance returns to IDLE and drops the request.
- WAIT:
  - imem_rsp_valid with !err: instr_out=rsp_data, fetch_addr=imem_req_addr, instr_en=1 next cycle; go to IDLE.
  - imem_rsp_valid with err: fetch_err pulse, instr_out unchanged; go to IDLE.
  - The counter increments each cycle without a response. On reaching TIMEOUT: fetch_err pulse and go to IDLE. A late response arriving in IDLE is ignored.
  - flush without a response goes to DRAIN; flush coincident with a response discards that response and goes to IDLE.
- DRAIN:
  - Waits for imem_rsp_valid and discards it without a pulse, then goes to IDLE.
  - Timeout also applies in DRAIN, silently (no fetch_err).
- fetch_en outside IDLE is ignored; no queuing.
- Flush in IDLE has no effect.
- Latency, best case: fetch_en at cycle N; req_valid at N+1; ready at N+1; rsp_valid at N+2; instr_en at N+3.
- instr_en and fetch_err are never high together; each is high for exactly one cycle.
- instr_out holds its value between fetches.
- rst asserted mid-fetch returns everything to reset values on the next edge. Any later response is ignored because the block is in IDLE.

Decomposition:
- Shared package npc_ifu_pkg:
  - FSM state encoding (2-bit enum IDLE/REQ/WAIT/DRAIN).
  - Default RESET_PC, IW and AW constants.
  - Misalignment mask constant.
- No sub-module. FSM, counter and pc register sit in one module of about 150–200 lines.

Test Plan:
- Reset, then fetch_en at pc=0x8000_0000, ready immediate, rsp data 0x00100073 two cycles later. Required: req_addr=0x8000_0000; instr_en for one cycle at N+3 with instr_out=0x00100073 and fetch_addr=0x8000_0000.
- pc_ld next_pc=0x8000_0002, then fetch_en. Required: no imem_req_valid; fetch_err for one cycle; state stays IDLE.
- ready held low for 5 cycles, then rsp_err=1. Required: req_valid and addr stable for all 5 cycles; fetch_err pulse; instr_out keeps its previous value.
- TIMEOUT=4 and no response. Required: fetch_err exactly 4 cycles after acceptance. A response arriving 2 cycles later causes no instr_en.
- flush in WAIT, response 3 cycles later. Required: state goes to DRAIN, response discarded with no instr_en or fetch_err, then IDLE. A new fetch_en then succeeds normally.
- pc_ld next_pc=0x8000_0100 during WAIT. Required: in-flight fetch_addr remains the old pc; pc_out=0x8000_0100; the next fetch uses 0x8000_0100.
